// File: rtl/mb2raster_ram.sv
// mb2raster_ram
// Collects reconstructed macroblocks (32-bit words, 96 per MB, one 16-row
// stripe at a time) into one of two stripe banks. Each completed stripe is
// re-emitted as an 8-bit raster stream in the camera line format:
//   even rows: Y0 U0 Y1 V0 ... (2*H bytes), odd rows: Y only (H bytes).
// The writer fills one bank while the reader drains the other (ping-pong).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      macroblock word, MSB byte is the leftmost pixel
//   in_valid     in_data valid
//   in_ready     a word can be accepted (transfer on in_valid && in_ready)
//   out_data     raster byte
//   out_valid    out_data valid (transfer on out_valid && out_ready)
//   out_ready    downstream accepts the byte
//   out_eol      out_data is the last byte of a raster row
//   out_eos      out_data is the last byte of the stripe (implies out_eol)
module mb2raster_ram #(
    parameter int unsigned H_PIXELS = 1280,
    localparam int unsigned MB_PER_ROW = H_PIXELS / 16,
    localparam int unsigned DATA_WIDTH_I = 32,
    localparam int unsigned DATA_WIDTH_O = 8,
    localparam int unsigned Y_BANK_SIZE = 16 * H_PIXELS,
    localparam int unsigned UV_BANK_SIZE = 8 * H_PIXELS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_I-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH_O-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_eol,
    output logic                    out_eos
);

    localparam int unsigned YAW  = $clog2(2 * Y_BANK_SIZE);
    localparam int unsigned UVAW = $clog2(2 * UV_BANK_SIZE);
    localparam int unsigned BW   = $clog2(2 * H_PIXELS);
    localparam int unsigned MBW  = (MB_PER_ROW > 1) ? $clog2(MB_PER_ROW) : 1;

    // Both banks live in one array each; the bank bit selects the upper half.
    logic [DATA_WIDTH_O-1:0] y_mem  [2*Y_BANK_SIZE];
    logic [DATA_WIDTH_O-1:0] uv_mem [2*UV_BANK_SIZE];

    logic [1:0]     full_q, full_d;
    logic           wb_q, rb_q;
    logic [6:0]     w_cnt_q;
    logic [MBW-1:0] mb_cnt_q;

    // Read position of the byte held in the output register, or of the next
    // byte to fetch while out_valid is low.
    logic [3:0]     row_q;
    logic [BW-1:0]  byte_q;

    logic                    out_valid_q, out_eol_q, out_eos_q;
    logic [DATA_WIDTH_O-1:0] out_data_q;

    // ---------------------------------------------------------------- write side
    logic            in_fire, w_luma, w_last_word, w_last_mb, stripe_done;
    int unsigned     w_col;
    logic [YAW-1:0]  y_waddr;
    logic [UVAW-1:0] uv_waddr;

    assign in_ready    = ~full_q[wb_q];
    assign in_fire     = in_valid && in_ready;
    assign w_luma      = ~w_cnt_q[6];
    assign w_last_word = (w_cnt_q == 7'd95);
    assign w_last_mb   = (mb_cnt_q == MBW'(MB_PER_ROW - 1));
    assign stripe_done = in_fire && w_last_word && w_last_mb;

    // Luma rows come from w[5:2]; chroma words 64..95 map to rows w[4:2].
    assign w_col    = 32'(mb_cnt_q) * 16 + 32'(w_cnt_q[1:0]) * 4;
    assign y_waddr  = YAW'(32'(wb_q) * Y_BANK_SIZE + 32'(w_cnt_q[5:2]) * H_PIXELS + w_col);
    assign uv_waddr = UVAW'(32'(wb_q) * UV_BANK_SIZE + 32'(w_cnt_q[4:2]) * H_PIXELS + w_col);

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int j = 0; j < 4; j++) begin
                if (w_luma) begin
                    y_mem[y_waddr + YAW'(j)] <= in_data[DATA_WIDTH_I-1-8*j -: 8];
                end else begin
                    uv_mem[uv_waddr + UVAW'(j)] <= in_data[DATA_WIDTH_I-1-8*j -: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read side
    logic            rd_fire, step, load;
    logic            nxt_rb;
    logic [3:0]      nxt_row;
    logic [BW-1:0]   nxt_byte, rd_pix, row_end;
    logic            rd_is_uv, nxt_eol, nxt_eos;
    logic [YAW-1:0]  y_raddr;
    logic [UVAW-1:0] uv_raddr;

    assign rd_fire = out_valid_q && out_ready;

    always_comb begin
        nxt_rb   = rb_q;
        nxt_row  = row_q;
        nxt_byte = byte_q;
        step     = 1'b0;
        load     = 1'b0;
        if (rd_fire) begin
            step = 1'b1;
            if (out_eos_q) begin
                // Jump straight to the other bank so a full bank streams with
                // no bubble; its full flag is only sampled as registered.
                nxt_rb   = ~rb_q;
                nxt_row  = 4'd0;
                nxt_byte = '0;
                load     = full_q[~rb_q];
            end else if (out_eol_q) begin
                nxt_row  = row_q + 4'd1;
                nxt_byte = '0;
                load     = 1'b1;
            end else begin
                nxt_byte = byte_q + BW'(1);
                load     = 1'b1;
            end
        end else if (!out_valid_q) begin
            step = 1'b1;
            load = full_q[rb_q];
        end
    end

    // Even rows interleave Y (even bytes) with UV (odd bytes) at half rate.
    assign rd_is_uv = ~nxt_row[0] & nxt_byte[0];
    assign rd_pix   = nxt_row[0] ? nxt_byte : (nxt_byte >> 1);
    assign y_raddr  = YAW'(32'(nxt_rb) * Y_BANK_SIZE + 32'(nxt_row) * H_PIXELS + 32'(rd_pix));
    assign uv_raddr = UVAW'(32'(nxt_rb) * UV_BANK_SIZE + 32'(nxt_row[3:1]) * H_PIXELS
                            + 32'(rd_pix));
    assign row_end  = nxt_row[0] ? BW'(H_PIXELS - 1) : BW'(2 * H_PIXELS - 1);
    assign nxt_eol  = (nxt_byte == row_end);
    assign nxt_eos  = nxt_eol && (nxt_row == 4'd15);

    // Write completion and read completion always target different banks.
    always_comb begin
        full_d = full_q;
        if (rd_fire && out_eos_q) full_d[rb_q] = 1'b0;
        if (stripe_done)          full_d[wb_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            w_cnt_q     <= '0;
            mb_cnt_q    <= '0;
            row_q       <= '0;
            byte_q      <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eos_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q <= full_d;
            if (in_fire) begin
                if (w_last_word) begin
                    w_cnt_q <= '0;
                    if (w_last_mb) begin
                        mb_cnt_q <= '0;
                        wb_q     <= ~wb_q;
                    end else begin
                        mb_cnt_q <= mb_cnt_q + MBW'(1);
                    end
                end else begin
                    w_cnt_q <= w_cnt_q + 7'd1;
                end
            end
            if (step) begin
                rb_q        <= nxt_rb;
                row_q       <= nxt_row;
                byte_q      <= nxt_byte;
                out_valid_q <= load;
                if (load) begin
                    out_data_q <= rd_is_uv ? uv_mem[uv_raddr] : y_mem[y_raddr];
                    out_eol_q  <= nxt_eol;
                    out_eos_q  <= nxt_eos;
                end else begin
                    out_eol_q  <= 1'b0;
                    out_eos_q  <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eos   = out_eos_q;

endmodule

// File: tb/tb_mb2raster_ram.sv
// Self-checking bench for mb2raster_ram with H_PIXELS=32 (2 MBs per stripe,
// 192 words in, 768 bytes out). Expected raster bytes are generated from the
// pixel pattern functions and queued as each stripe is driven.
module tb_mb2raster_ram;

    localparam int H = 32;
    localparam int STRIPE_BYTES = 24 * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_eol;
    logic        out_eos;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bubbles = 0;
    int eos_cyc = -1;
    int rise_cyc = -1;
    logic [9:0] exp_q[$];
    logic [9:0] cap[$];

    mb2raster_ram #(.H_PIXELS(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .out_eos   (out_eos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Stripe 0 uses the reference pattern; others use a salted pattern.
    function automatic logic [7:0] ypix(int s, int r, int c);
        if (s == 0) return 8'((r * H + c) & 255);
        return 8'((r * 37 + c * 11 + s * 53) & 255);
    endfunction

    function automatic logic [7:0] uvpix(int s, int cr, int c);
        if (s == 0) return (c % 2 == 0) ? 8'(128 + c / 2) : 8'(192 + c / 2);
        return 8'((cr * 29 + c * 7 + s * 71 + 90) & 255);
    endfunction

    function automatic logic [31:0] word_of(int s, int m, int w);
        logic [31:0] d;
        int col;
        d = '0;
        for (int j = 0; j < 4; j++) begin
            col = m * 16 + (w % 4) * 4 + j;
            d[31-8*j -: 8] = (w < 64) ? ypix(s, w / 4, col) : uvpix(s, (w - 64) / 4, col);
        end
        return d;
    endfunction

    task automatic push_expected(int s);
        int len;
        logic [7:0] d;
        logic eol, eos;
        for (int r = 0; r < 16; r++) begin
            len = (r % 2 == 1) ? H : 2 * H;
            for (int b = 0; b < len; b++) begin
                if (r % 2 == 1)      d = ypix(s, r, b);
                else if (b % 2 == 0) d = ypix(s, r, b / 2);
                else                 d = uvpix(s, r / 2, b / 2);
                eol = (b == len - 1);
                eos = eol && (r == 15);
                exp_q.push_back({eos, eol, d});
            end
        end
    endtask

    task automatic drive_word(logic [31:0] d);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout got=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_words(int s, int first, int last);
        for (int i = first; i <= last; i++) drive_word(word_of(s, i / 96, i % 96));
    endtask

    task automatic send_stripe(int s);
        push_expected(s);
        send_words(s, 0, 191);
    endtask

    task automatic consume(int n, bit rnd);
        int got, waited;
        bit started, prev_stall;
        logic [9:0] obs, e;
        got = 0;
        waited = 0;
        started = 0;
        prev_stall = 0;
        bubbles = 0;
        while (got < n && waited < n * 4 + 6000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            obs = {out_eos, out_eol, out_data};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL valid_hold got=%b required=1", out_valid);
                end
            end
            prev_stall = 0;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_byte got=%h required=none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL byte_%0d got=%h required=%h", cap.size(), obs, e);
                    end
                end
                cap.push_back(obs);
                if (out_eos && eos_cyc < 0) eos_cyc = cyc;
                got++;
                started = 1;
            end else if (out_valid) begin
                prev_stall = 1;
                if (exp_q.size() > 0) begin
                    checks++;
                    if (obs !== exp_q[0]) begin
                        failures++;
                        $display("FAIL stall_hold got=%h required=%h", obs, exp_q[0]);
                    end
                end
            end else if (started) begin
                bubbles++;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL consume_timeout got=%0d required=%0d", got, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        cap.delete();
    endtask

    task automatic check_reset_outputs(string tag);
        logic [11:0] got;
        got = {in_ready, out_valid, out_eol, out_eos, out_data};
        checks++;
        if (got !== 12'h800) begin
            failures++;
            $display("FAIL %s got=%h required=800", tag, got);
        end
    endtask

    task automatic check_queue_empty(string tag);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_leftover got=%0d required=0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset_outputs");
        do_reset();
        check_reset_outputs("post_reset_outputs");
    endtask

    task automatic test_pattern();
        logic [7:0] row0[4];
        logic [7:0] row1[4];
        int n_eol, n_eos;
        bit found;
        row0 = '{8'h00, 8'h80, 8'h01, 8'hC0};
        row1 = '{8'h20, 8'h21, 8'h22, 8'h23};
        do_reset();
        push_expected(0);
        send_words(0, 0, 190);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL early_valid got=%b required=0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send_words(0, 191, 191);
        found = 0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL first_valid_latency got=0 required=1");
        end
        @(posedge clk);
        #1;
        consume(STRIPE_BYTES, 0);
        checks++;
        if (cap.size() != STRIPE_BYTES) begin
            failures++;
            $display("FAIL stripe_len got=%0d required=%0d", cap.size(), STRIPE_BYTES);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (cap[i][7:0] !== row0[i]) begin
                    failures++;
                    $display("FAIL row0_b%0d got=%h required=%h", i, cap[i][7:0], row0[i]);
                end
                if (cap[64+i][7:0] !== row1[i]) begin
                    failures++;
                    $display("FAIL row1_b%0d got=%h required=%h", i, cap[64+i][7:0], row1[i]);
                end
            end
            n_eol = 0;
            n_eos = 0;
            foreach (cap[i]) begin
                n_eol += int'(cap[i][8]);
                n_eos += int'(cap[i][9]);
            end
            checks += 4;
            if (cap[63][8] !== 1'b1 || cap[62][8] !== 1'b0) begin
                failures++;
                $display("FAIL row0_eol got=%b%b required=01", cap[62][8], cap[63][8]);
            end
            if (cap[95][8] !== 1'b1) begin
                failures++;
                $display("FAIL row1_eol got=%b required=1", cap[95][8]);
            end
            if (n_eol != 16) begin
                failures++;
                $display("FAIL eol_count got=%0d required=16", n_eol);
            end
            if (n_eos != 1 || cap[767][9] !== 1'b1) begin
                failures++;
                $display("FAIL eos_pos got=%0d/%b required=1/1", n_eos, cap[767][9]);
            end
        end
        check_queue_empty("pattern");
    endtask

    task automatic test_pingpong();
        do_reset();
        send_stripe(1);
        send_stripe(2);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL both_full_ready got=%b required=0", in_ready);
        end
        @(posedge clk);
        #1;
        eos_cyc = -1;
        rise_cyc = -1;
        fork
            send_stripe(3);
            consume(3 * STRIPE_BYTES, 0);
            begin
                for (int k = 0; k < 4000 && rise_cyc < 0; k++) begin
                    @(negedge clk);
                    if (in_ready) rise_cyc = cyc;
                end
            end
        join
        checks++;
        if (eos_cyc < 0 || rise_cyc != eos_cyc + 1) begin
            failures++;
            $display("FAIL ready_rise got=%0d required=%0d", rise_cyc, eos_cyc + 1);
        end
        check_queue_empty("pingpong");
    endtask

    task automatic test_backpressure();
        do_reset();
        fork
            send_stripe(6);
            consume(STRIPE_BYTES, 1);
        join
        check_queue_empty("backpressure");
    endtask

    task automatic test_back_to_back();
        do_reset();
        fork
            begin
                send_stripe(7);
                send_stripe(8);
            end
            consume(2 * STRIPE_BYTES, 0);
        join
        checks++;
        if (bubbles != 0) begin
            failures++;
            $display("FAIL throughput_bubbles got=%0d required=0", bubbles);
        end
        check_queue_empty("back_to_back");
    endtask

    task automatic test_reset_mid();
        do_reset();
        fork
            send_stripe(4);
            consume(300, 0);
        join
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_reset_outputs");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            check_reset_outputs("after_release_idle");
        end
        @(posedge clk);
        #1;
        fork
            send_stripe(5);
            consume(STRIPE_BYTES, 0);
        join
        check_queue_empty("reset_mid");
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_pingpong();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mb2raster_ram.md
Name: mb2raster_ram

Overview:
- Output-side counterpart of the raster-to-macroblock YUV buffer. It sits at the decoder/reconstruction end of the H.264 path.
- Accepts reconstructed macroblocks as 32-bit words, one 16-row stripe at a time, in macroblock order.
- Re-emits each stripe as an 8-bit raster stream in the camera line format: even rows YUYV (2*H bytes), odd rows Y only (H bytes).
- Two stripe banks (ping-pong) let stripe N+1 be written while stripe N is read out.

Parameters:
- H_PIXELS, 1280, luma pixels per row; must be a multiple of 16.
- MB_PER_ROW, H_PIXELS/16, macroblocks per stripe.
- DATA_WIDTH_I, 32, input word width (4 bytes; MSB byte is the leftmost pixel).
- DATA_WIDTH_O, 8, output byte width.
- Y_BANK_SIZE, 16*H_PIXELS, luma bytes per bank.
- UV_BANK_SIZE, 8*H_PIXELS, interleaved chroma bytes per bank.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- in_data  in  32  macroblock word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word. A transfer occurs when in_valid && in_ready.
- out_data  out  8  raster byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte. A transfer occurs when out_valid && out_ready.
- out_eol  out  1  qualifies out_data as the last byte of a raster row.
- out_eos  out  1  qualifies out_data as the last byte of the stripe (row 15); implies out_eol.

Behaviour:
- Reset: all counters 0; both bank full flags 0; write bank wb=0, read bank rb=0.
- Reset outputs: in_ready=1, out_valid=0, out_eol=0, out_eos=0, out_data=0.
- Reset mid-stripe discards all buffered data; no partial output after release.
- Input word order per macroblock (96 words, w=0..95):
  - w<64: luma. row=w>>2, col=m*16+(w&3)*4+j for byte j=0..3 (j=0 is MSB). Write Y[wb][row*H+col].
  - w>=64: chroma. u=w-64, row=u>>2 (0..7), same col formula. Write UV[wb][row*H+col]. Chroma rows are interleaved U0 V0 U1 V1...
- Input counters:
  - w_cnt is 7 bits and wraps 95->0, incrementing mb_cnt.
  - mb_cnt wraps MB_PER_ROW-1 -> 0. That wrap marks the stripe complete: full[wb]<=1 and wb toggles on the same edge.
- in_ready = !full[wb], combinational from registers (no dependency on in_valid).
  - When both banks are full, in_ready=0 until the read side frees a bank.
- Read side is active when full[rb]=1. row_cnt (0..15) and byte_cnt sequence:
  - Even row r: byte_cnt runs 0..2H-1. Byte b = Y[rb][r*H+(b>>1)] if b even, else UV[rb][(r>>1)*H+(b>>1)]. Result is Y0 U0 Y1 V0...
  - Odd row r: byte_cnt runs 0..H-1. Byte b = Y[rb][r*H+b].
  - out_eol=1 on the final byte_cnt of each row. out_eos=1 on the final byte of row 15.
  - On an accepted eos byte: full[rb]<=0, rb toggles, counters reset to 0.
- Read latency:
  - First out_valid within 2 cycles of full[rb] rising.
  - With out_ready held high, 1 byte/cycle sustained, including across row and stripe boundaries when the next bank is already full.
- Hold rule: while out_valid && !out_ready, out_data, out_eol and out_eos stay stable. Once out_valid is asserted it does not drop until the byte is accepted.
- Simultaneous events:
  - Write completion sets full on wb while read completion clears full on rb in the same cycle. These are always different banks; both take effect.
  - A write completing into a bank is visible to the read side no earlier than the next cycle.
- Bank read-while-write: never the same bank. No address conflict is permitted.
- Stripe bytes out = 24*H; words in = 96*MB_PER_ROW.

Test Plan (H_PIXELS=32 unless noted; 2 MBs, 192 words/stripe, 768 bytes/stripe):
- Reset state: after reset -> in_ready=1, out_valid=0. Feed 191 words -> out_valid stays 0. Word 192 -> out_valid within 2 cycles.
- Pattern check: Y byte = (row*32+col)&0xFF, U=0x80+col/2, V=0xC0+col/2.
  - Row 0 bytes 0..3 -> 00,80,01,C0.
  - Row 1 bytes 0..3 -> 20,21,22,23.
  - Row 0 length 64 with out_eol on byte 63. Row 1 length 32.
  - out_eos on byte 767 only.
- Ping-pong fill:
  - out_ready=0, stream 2 stripes -> in_ready drops after word 384.
  - Third stripe stalls until 768 bytes are drained; in_ready rises the cycle after the eos transfer.
- Backpressure: toggle out_ready pseudo-randomly -> byte sequence identical to the out_ready=1 run; out_data stable during stalls.
- Throughput: out_ready=1, in_valid=1 continuously -> 1536 output bytes over 2 stripes with no bubble between stripe 1 eos and stripe 2 byte 0.
- Reset mid-readout: assert rst_n low at byte 300 -> outputs at reset values. New stripe after release -> starts at row 0 byte 0 with correct data.
